// File: rtl/frv_asi_arb.sv
// Two-requester round-robin arbiter/sequencer in front of the shared ASI unit.
// One transaction in flight: grant, hold operands until asi_ready (or timeout), return result.
module frv_asi_arb #(
  parameter int XLEN     = 32,
  parameter int OPW      = 7,
  parameter int MAX_BUSY = 32
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [OPW-1:0]  req0_uop,
  input  logic [OPW-1:0]  req1_uop,
  input  logic [XLEN-1:0] req0_rs1,
  input  logic [XLEN-1:0] req0_rs2,
  input  logic [XLEN-1:0] req1_rs1,
  input  logic [XLEN-1:0] req1_rs2,
  input  logic [1:0]      req0_shamt,
  input  logic [1:0]      req1_shamt,
  output logic [1:0]      rsp_valid,
  input  logic [1:0]      rsp_ready,
  output logic [XLEN-1:0] rsp_result,
  output logic            rsp_err,
  input  logic            flush0,
  output logic            asi_valid,
  input  logic            asi_ready,
  output logic            asi_flush,
  output logic [OPW-1:0]  asi_uop,
  output logic [XLEN-1:0] asi_rs1,
  output logic [XLEN-1:0] asi_rs2,
  output logic [1:0]      asi_shamt,
  input  logic [XLEN-1:0] asi_result
);
  localparam int CW = (MAX_BUSY > 1) ? $clog2(MAX_BUSY) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BUSY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  typedef struct packed {
    logic [OPW-1:0]  uop;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [1:0]      shamt;
  } op_t;

  state_e          state_q, state_d;
  logic            owner_q, owner_d;
  logic            last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  op_t             op_q, op_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            err_q, err_d;

  op_t  [1:0] req_op;
  logic [1:0] elig;
  logic       kill0;

  assign req_op[0] = {req0_uop, req0_rs1, req0_rs2, req0_shamt};
  assign req_op[1] = {req1_uop, req1_rs1, req1_rs2, req1_shamt};

  // A requester-0 request raised together with its own flush is never granted.
  assign elig  = {req_valid[1], req_valid[0] & ~flush0};
  assign kill0 = flush0 & ~owner_q;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    res_d     = res_q;
    err_d     = err_q;
    req_ready = 2'b00;
    asi_valid = 1'b0;
    asi_flush = 1'b0;
    rsp_valid = 2'b00;
    case (state_q)
      IDLE: begin
        if (g_resetn) req_ready = (&elig) ? (last_q ? 2'b01 : 2'b10) : elig;
        if (|req_ready) begin
          owner_d = req_ready[1];
          last_d  = req_ready[1];
          op_d    = req_op[req_ready[1]];
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        asi_valid = 1'b1;
        // Flush beats both completion and timeout in the same cycle.
        if (kill0) begin
          asi_flush = 1'b1;
          state_d   = IDLE;
        end else if (asi_ready) begin
          res_d   = asi_result;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          asi_flush = 1'b1;
          res_d     = '0;
          err_d     = 1'b1;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        rsp_valid[owner_q] = 1'b1;
        if (kill0 || rsp_ready[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      op_q    <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  assign asi_uop    = op_q.uop;
  assign asi_rs1    = op_q.rs1;
  assign asi_rs2    = op_q.rs2;
  assign asi_shamt  = op_q.shamt;
  assign rsp_result = res_q;
  assign rsp_err    = err_q & (state_q == RESP);

endmodule

// File: tb/tb_frv_asi_arb.sv
// Directed + random bench for frv_asi_arb against a transaction-level reference model.
module tb_frv_asi_arb;
  localparam int XLEN = 32, OPW = 7, MB = 4;

  logic g_clk = 1'b0, g_resetn = 1'b0;
  logic [1:0] req_valid = '0, req_ready, rsp_valid, rsp_ready = '0;
  logic [OPW-1:0] req0_uop = '0, req1_uop = '0, asi_uop;
  logic [XLEN-1:0] req0_rs1 = '0, req0_rs2 = '0, req1_rs1 = '0, req1_rs2 = '0;
  logic [XLEN-1:0] rsp_result, asi_rs1, asi_rs2, asi_result = '0;
  logic [1:0] req0_shamt = '0, req1_shamt = '0, asi_shamt;
  logic flush0 = 1'b0, asi_valid, asi_ready = 1'b0, asi_flush, rsp_err;

  int n_chk = 0, n_fail = 0;

  frv_asi_arb #(.XLEN(XLEN), .OPW(OPW), .MAX_BUSY(MB)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn), .req_valid(req_valid), .req_ready(req_ready),
    .req0_uop(req0_uop), .req1_uop(req1_uop), .req0_rs1(req0_rs1), .req0_rs2(req0_rs2),
    .req1_rs1(req1_rs1), .req1_rs2(req1_rs2), .req0_shamt(req0_shamt), .req1_shamt(req1_shamt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_err(rsp_err),
    .flush0(flush0), .asi_valid(asi_valid), .asi_ready(asi_ready), .asi_flush(asi_flush),
    .asi_uop(asi_uop), .asi_rs1(asi_rs1), .asi_rs2(asi_rs2), .asi_shamt(asi_shamt),
    .asi_result(asi_result)
  );

  always #5 g_clk = ~g_clk;

  // Reference model: one transaction in flight, tracked as phase flags.
  bit m_busy, m_resp, m_owner, m_last, m_err;
  int m_wait;
  logic [OPW-1:0] m_uop;
  logic [XLEN-1:0] m_rs1, m_rs2, m_res;
  logic [1:0] m_sh;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_resp = 0; m_owner = 0; m_last = 1; m_err = 0; m_wait = 0;
    m_uop = '0; m_rs1 = '0; m_rs2 = '0; m_sh = '0; m_res = '0;
  endtask

  function automatic logic [1:0] exp_grant();
    logic e0, e1;
    e0 = req_valid[0] && !flush0;
    e1 = req_valid[1];
    if (m_busy || m_resp) return 2'b00;
    if (e0 && e1) return m_last ? 2'b01 : 2'b10;
    return {e1, e0};
  endfunction

  task automatic model_check();
    bit abort0, tmo;
    abort0 = flush0 && !m_owner;
    tmo = !abort0 && !asi_ready && (m_wait + 1 == MB);
    chk("req_ready", 32'(req_ready), 32'(exp_grant()));
    chk("asi_valid", 32'(asi_valid), 32'(m_busy));
    chk("asi_flush", 32'(asi_flush), 32'(m_busy && (abort0 || tmo)));
    chk("rsp_valid", 32'(rsp_valid), m_resp ? (m_owner ? 32'd2 : 32'd1) : 32'd0);
    chk("rsp_err", 32'(rsp_err), 32'(m_resp && m_err));
    if (m_resp) chk("rsp_result", rsp_result, m_res);
    if (m_busy) begin
      chk("asi_uop", 32'(asi_uop), 32'(m_uop));
      chk("asi_rs1", asi_rs1, m_rs1);
      chk("asi_rs2", asi_rs2, m_rs2);
      chk("asi_shamt", 32'(asi_shamt), 32'(m_sh));
    end
  endtask

  task automatic model_tick();
    logic [1:0] g;
    g = exp_grant();
    if (g != 2'b00) begin
      m_owner = g[1]; m_last = g[1]; m_busy = 1; m_wait = 0;
      m_uop = g[1] ? req1_uop : req0_uop;
      m_rs1 = g[1] ? req1_rs1 : req0_rs1;
      m_rs2 = g[1] ? req1_rs2 : req0_rs2;
      m_sh  = g[1] ? req1_shamt : req0_shamt;
    end else if (m_busy) begin
      if (flush0 && !m_owner) m_busy = 0;
      else if (asi_ready) begin m_res = asi_result; m_err = 0; m_busy = 0; m_resp = 1; end
      else if (m_wait + 1 == MB) begin m_res = '0; m_err = 1; m_busy = 0; m_resp = 1; end
      else m_wait++;
    end else if (m_resp) begin
      if ((flush0 && !m_owner) || rsp_ready[m_owner]) m_resp = 0;
    end
  endtask

  // Inputs are set just after a negedge; check, clock, advance model.
  task automatic cyc();
    #1 model_check();
    @(posedge g_clk);
    model_tick();
    @(negedge g_clk);
  endtask

  task automatic rand_ops();
    req0_uop = OPW'($urandom); req1_uop = OPW'($urandom);
    req0_rs1 = $urandom; req0_rs2 = $urandom; req1_rs1 = $urandom; req1_rs2 = $urandom;
    req0_shamt = 2'($urandom); req1_shamt = 2'($urandom);
    asi_result = $urandom;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_asi_valid"}, 32'(asi_valid), 32'd0);
    chk({tag, "_asi_flush"}, 32'(asi_flush), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "_rsp_result"}, rsp_result, 32'd0);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_asi_rs1"}, asi_rs1, 32'd0);
  endtask

  task automatic mid_reset(input string tag);
    #2 g_resetn = 1'b0;
    #1 chk_reset_outs(tag);
    model_reset();
    @(negedge g_clk);
    g_resetn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] grants[$];
    int nvalid;
    model_reset();
    req_valid = 2'b11;
    #2 chk_reset_outs("reset");
    @(negedge g_clk);
    g_resetn = 1'b1;
    req_valid = 2'b00;

    // Round robin from reset: both valid, instant completion.
    req_valid = 2'b11; asi_ready = 1'b1; rsp_ready = 2'b11;
    for (int i = 0; i < 12; i++) begin
      rand_ops();
      #1 if (req_ready != 2'b00) grants.push_back(req_ready);
      chk("rr_onehot", 32'($countones(req_ready) <= 1), 32'd1);
      cyc();
    end
    req_valid = 2'b00;
    chk("rr_count", grants.size(), 32'd4);
    for (int i = 0; i < grants.size(); i++)
      chk("rr_order", 32'(grants[i]), (i % 2 == 0) ? 32'd1 : 32'd2);

    // Single op, requester 0.
    asi_ready = 1'b0; rsp_ready = 2'b00;
    req_valid = 2'b01; req0_uop = 7'd5; req0_rs1 = 32'h11223344; req0_rs2 = 32'h0; req0_shamt = 2'd1;
    cyc();
    req_valid = 2'b00; asi_ready = 1'b1; asi_result = 32'hDEADBEEF;
    #1 chk("op_asi_valid", 32'(asi_valid), 32'd1);
    chk("op_asi_uop", 32'(asi_uop), 32'd5);
    chk("op_asi_rs1", asi_rs1, 32'h11223344);
    cyc();
    asi_ready = 1'b0; rsp_ready = 2'b01;
    #1 chk("op_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("op_rsp_result", rsp_result, 32'hDEADBEEF);
    chk("op_rsp_err", 32'(rsp_err), 32'd0);
    cyc();
    rsp_ready = 2'b00;

    // Multi-cycle stall on requester 1, then response backpressure.
    req_valid = 2'b10; rand_ops(); asi_result = 32'hCAFE0001;
    cyc();
    nvalid = 0;
    for (int i = 0; i < 4; i++) begin
      rand_ops(); asi_result = 32'hCAFE0001;
      asi_ready = (i == 3);
      #1 nvalid += int'(asi_valid);
      cyc();
    end
    asi_ready = 1'b0;
    chk("stall_valid_cycles", nvalid, 32'd4);
    for (int i = 0; i < 5; i++) begin
      rsp_ready = (i < 3) ? 2'b01 : 2'b00;
      #1 chk("bp_rsp_result", rsp_result, 32'hCAFE0001);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      cyc();
    end
    rsp_ready = 2'b10; req_valid = 2'b00;
    cyc();
    rsp_ready = 2'b00;

    // Flush: blocked grant, then flush in BUSY beating asi_ready.
    req_valid = 2'b01; flush0 = 1'b1;
    #1 chk("flush_no_grant", 32'(req_ready), 32'd0);
    cyc();
    flush0 = 1'b0;
    cyc();
    req_valid = 2'b00; flush0 = 1'b1; asi_ready = 1'b1;
    #1 chk("flush_pulse", 32'(asi_flush), 32'd1);
    cyc();
    flush0 = 1'b0; asi_ready = 1'b0;
    #1 chk("flush_no_rsp", 32'(rsp_valid), 32'd0);
    chk("flush_idle", 32'(asi_valid), 32'd0);
    cyc();
    // flush0 ignored while requester 1 owns the unit.
    req_valid = 2'b10;
    cyc();
    req_valid = 2'b00; flush0 = 1'b1;
    #1 chk("flush1_no_pulse", 32'(asi_flush), 32'd0);
    cyc();
    asi_ready = 1'b1;
    cyc();
    asi_ready = 1'b0;
    #1 chk("flush1_rsp", 32'(rsp_valid), 32'd2);
    cyc();
    flush0 = 1'b0; rsp_ready = 2'b10;
    cyc();
    rsp_ready = 2'b00;

    // Timeout on requester 0.
    req_valid = 2'b01;
    cyc();
    req_valid = 2'b00;
    for (int i = 0; i < MB; i++) begin
      #1 chk("tmo_flush", 32'(asi_flush), 32'(i == MB - 1));
      cyc();
    end
    #1 chk("tmo_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("tmo_rsp_err", 32'(rsp_err), 32'd1);
    chk("tmo_rsp_result", rsp_result, 32'd0);
    rsp_ready = 2'b01;
    cyc();
    rsp_ready = 2'b00;

    // Async reset in the middle of BUSY.
    req_valid = 2'b10;
    cyc();
    cyc();
    mid_reset("midbusy");
    req_valid = 2'b00;
    cyc();

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      rand_ops();
      req_valid = 2'($urandom);
      rsp_ready = 2'($urandom);
      asi_ready = ($urandom_range(2) == 0);
      flush0 = ($urandom_range(7) == 0);
      if (i == 700) mid_reset("rand");
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/frv_asi_arb.md
Name: frv_asi_arb

Overview:
- Two-requester arbiter and sequencer in front of the shared frv_asi algorithm-specific-instruction unit.
- Requester 0 is the core execute stage; requester 1 is an auxiliary engine, e.g. a key-schedule or hash offload.
- Grants one request at a time, latches its operands, holds asi_valid with stable operands until asi_ready, captures the result and returns it with a response handshake.
- Handles flush of the core's request and a busy watchdog.

Parameters:
- XLEN, 32, data width of rs1/rs2/result.
- OPW, 7, width of the uop field forwarded to the ASI unit.
- MAX_BUSY, 32, maximum cycles in BUSY before a timeout abort (>=1).

Ports:
- g_clk  in  1  global clock.
- g_resetn  in  1  asynchronous active-low reset.
- req_valid  in  2  per-requester request valid; bit i = requester i.
- req_ready  out  2  per-requester accept; the request transfers when valid&ready.
- req0_uop, req1_uop  in  OPW each  operation.
- req0_rs1, req0_rs2, req1_rs1, req1_rs2  in  XLEN each  source operands.
- req0_shamt, req1_shamt  in  2 each  shift/byte-select immediate.
- rsp_valid  out  2  response valid, one-hot to the owner.
- rsp_ready  in  2  per-requester response accept.
- rsp_result  out  XLEN  captured result; shared, qualified by rsp_valid.
- rsp_err  out  1  response is a timeout error; qualified by rsp_valid.
- flush0  in  1  abort any request owned by requester 0.
- asi_valid  out  1  to ASI unit.
- asi_ready  in  1  from ASI unit.
- asi_flush  out  1  one-cycle flush pulse to ASI unit.
- asi_uop  out  OPW  latched operands.
- asi_rs1, asi_rs2  out  XLEN  latched operands.
- asi_shamt  out  2  latched operand.
- asi_result  in  XLEN  from ASI unit.

Behaviour:
- Reset (async, g_resetn=0):
  - state=IDLE, owner=0, last_grant=1, so requester 0 wins the first tie.
  - Counter cleared; all operand and result registers cleared.
  - Outputs: asi_valid=0, asi_flush=0, rsp_valid=0, rsp_err=0, rsp_result=0, req_ready=0.
  - Reset mid-operation drops the transaction silently; no response is produced.
- States: IDLE, BUSY, RESP.
- IDLE, arbitration:
  - req_ready is combinational: the one-hot grant among req_valid.
  - If both requesters are valid, grant the one not equal to last_grant (round robin). A single valid requester is granted immediately.
  - req_ready=0 for any requester in BUSY/RESP.
  - In IDLE, a requester-0 request with flush0=1 in the same cycle is not granted.
  - On grant: latch uop/rs1/rs2/shamt and owner; set last_grant=owner; clear counter; next state BUSY.
- BUSY:
  - asi_valid=1; asi_* outputs driven from the latches and stable for the whole state.
  - asi_ready=1: capture asi_result into rsp_result, rsp_err=0, next state RESP. This gives one BUSY cycle minimum for single-cycle ops.
  - Otherwise the counter increments. When the counter reaches MAX_BUSY-1 without asi_ready: asi_flush=1 for one cycle, rsp_result=0, rsp_err=1, next state RESP.
  - asi_valid=0 in IDLE and RESP.
- RESP:
  - rsp_valid[owner]=1.
  - rsp_ready[owner]=1: next state IDLE. rsp_ready of the non-owner is ignored.
- Latency: accept in cycle N; asi_valid from N+1. If asi_ready at N+k (k>=1), rsp_valid asserts from N+k+1. Fastest turnaround to a new grant: IDLE in N+k+2.
- flush0 (owner=0, state BUSY or RESP):
  - Abort to IDLE next cycle; no response.
  - asi_flush=1 for one cycle if state was BUSY.
  - flush0 takes priority over asi_ready in the same cycle and over a pending timeout.
  - flush0 has no effect when owner=1.
- Counter width is clog2(MAX_BUSY); it saturates, with no wrap-around possible before the timeout.
- asi_flush is never asserted for more than one consecutive cycle.

Test Plan:
- Single op, requester 0: uop=5, rs1=0x11223344, asi_ready asserted in the first BUSY cycle, asi_result=0xDEADBEEF -> asi_valid for 1 cycle; rsp_valid=2'b01 next cycle with rsp_result=0xDEADBEEF and rsp_err=0.
- Round robin: both req_valid held high for 4 transactions, asi_ready immediate -> grant order 0,1,0,1; req_ready never has 2 bits set.
- Multi-cycle stall: asi_ready low for 3 cycles -> asi_valid high 4 cycles with asi_rs1/rs2/uop unchanged; response after the 4th cycle.
- Backpressure: rsp_ready low for 5 cycles -> rsp_valid and rsp_result held; req_ready stays 0 despite req_valid[1]=1.
- Flush: requester 0 in BUSY, flush0=1 with asi_ready=1 in the same cycle -> asi_flush pulses 1 cycle, no rsp_valid, IDLE next cycle; flush0 while owner=1 -> no effect.
- Timeout with MAX_BUSY=4, asi_ready never asserted -> asi_flush at the 4th BUSY cycle; rsp_valid to owner with rsp_err=1 and rsp_result=0. An async reset asserted mid-BUSY clears all outputs immediately.
